// File: rtl/mlaccel_memarb.sv
// mlaccel_memarb: fixed-priority arbiter (compute > QPI > sequencer) for the single-ported
// main memory, with starvation counters that force-grant the QPI and sequencer ports.
`default_nettype none

module mlaccel_memarb #(
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clock,
  input  logic        reset,

  input  logic        c_valid,
  output logic        c_ready,
  input  logic [15:0] c_addr,
  input  logic [7:0]  c_wen,
  input  logic [63:0] c_wdata,
  output logic        c_rvalid,
  output logic [63:0] c_rdata,

  input  logic        q_valid,
  output logic        q_ready,
  input  logic [15:0] q_addr,
  input  logic [1:0]  q_wen,
  input  logic [15:0] q_wdata,
  output logic        q_rvalid,
  output logic [15:0] q_rdata,

  input  logic        s_valid,
  output logic        s_ready,
  input  logic [15:0] s_addr,
  output logic        s_rvalid,
  output logic [31:0] s_rdata,

  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wen,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata,

  output logic        stall
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic [7:0] wait_q;
  logic [7:0] wait_s;
  logic       force_q;
  logic       force_s;
  logic       grant_c;
  logic       grant_q;
  logic       grant_s;
  logic [2:0] ret_tag;   // one-hot {compute, qpi, sequencer} read return
  logic [2:0] ret_next;

  // QPI wins a simultaneous force; the sequencer gets its turn the next cycle.
  assign force_q = q_valid && (wait_q == LIMIT);
  assign force_s = s_valid && (wait_s == LIMIT) && !force_q;

  assign grant_c = c_valid && !force_q && !force_s;
  assign grant_q = force_q || (q_valid && !c_valid && !force_s);
  assign grant_s = force_s || (s_valid && !c_valid && !q_valid && !force_q);

  assign c_ready = grant_c;
  assign q_ready = grant_q;
  assign s_ready = grant_s;

  assign stall = (c_valid && !c_ready) || (q_valid && !q_ready) || (s_valid && !s_ready);

  always_comb begin
    mem_addr  = 16'h0000;
    mem_wen   = 8'h00;
    mem_wdata = 64'h0;
    if (grant_c) begin
      mem_addr  = c_addr;
      mem_wen   = c_wen;
      mem_wdata = c_wdata;
    end else if (grant_q) begin
      mem_addr  = q_addr;
      mem_wen   = {6'b0, q_wen};
      mem_wdata = {48'b0, q_wdata};
    end else if (grant_s) begin
      mem_addr  = s_addr;
    end
  end

  assign ret_next = {grant_c && (c_wen == 8'h00),
                     grant_q && (q_wen == 2'b00),
                     grant_s};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_q  <= 8'h00;
      wait_s  <= 8'h00;
      ret_tag <= 3'b000;
    end else begin
      ret_tag <= ret_next;

      if (!q_valid || q_ready)
        wait_q <= 8'h00;
      else if (wait_q < LIMIT)
        wait_q <= wait_q + 8'h01;

      if (!s_valid || s_ready)
        wait_s <= 8'h00;
      else if (wait_s < LIMIT)
        wait_s <= wait_s + 8'h01;
    end
  end

  assign c_rvalid = ret_tag[2];
  assign q_rvalid = ret_tag[1];
  assign s_rvalid = ret_tag[0];

  assign c_rdata = mem_rdata;
  assign q_rdata = mem_rdata[15:0];
  assign s_rdata = mem_rdata[31:0];

endmodule

`default_nettype wire

// File: tb/tb_mlaccel_memarb.sv
// Directed bench for mlaccel_memarb with a byte-lane memory model (1-cycle read latency).
`default_nettype none

module tb_mlaccel_memarb;

  logic        clock = 1'b0;
  logic        reset;
  logic        c_valid, c_ready, c_rvalid;
  logic [15:0] c_addr;
  logic [7:0]  c_wen;
  logic [63:0] c_wdata, c_rdata;
  logic        q_valid, q_ready, q_rvalid;
  logic [15:0] q_addr, q_wdata, q_rdata;
  logic [1:0]  q_wen;
  logic        s_valid, s_ready, s_rvalid;
  logic [15:0] s_addr;
  logic [31:0] s_rdata;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wen;
  logic [63:0] mem_wdata, mem_rdata;
  logic        stall;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] mem [0:65535];

  mlaccel_memarb #(.STARVE_LIMIT(4)) dut (
    .clock(clock), .reset(reset),
    .c_valid(c_valid), .c_ready(c_ready), .c_addr(c_addr), .c_wen(c_wen),
    .c_wdata(c_wdata), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .q_valid(q_valid), .q_ready(q_ready), .q_addr(q_addr), .q_wen(q_wen),
    .q_wdata(q_wdata), .q_rvalid(q_rvalid), .q_rdata(q_rdata),
    .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr),
    .s_rvalid(s_rvalid), .s_rdata(s_rdata),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall(stall)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    for (int i = 0; i < 8; i++)
      if (mem_wen[i]) mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
    mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    c_valid = 0; c_addr = 0; c_wen = 0; c_wdata = 0;
    q_valid = 0; q_addr = 0; q_wen = 0; q_wdata = 0;
    s_valid = 0; s_addr = 0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wen"}, mem_wen, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_stall"}, stall, 0);
    chk({tag, "_readies"}, {c_ready, q_ready, s_ready}, 0);
  endtask

  initial begin
    logic       w;
    logic [2:0] exp_g;
    logic [2:0] prev_g;

    reset = 1'b1;
    idle_inputs();
    #1;
    chk("rst_rvalids", {c_rvalid, q_rvalid, s_rvalid}, 0);
    chk_idle("rst_idle");
    cyc();
    cyc();
    reset = 1'b0;

    // Preload 0x0010 through a compute write
    c_valid = 1; c_addr = 16'h0010; c_wen = 8'hFF; c_wdata = 64'h1122334455667788;
    #1;
    chk("pre_c_ready", c_ready, 1);
    chk("pre_mem_wen", mem_wen, 8'hFF);
    chk("pre_mem_addr", mem_addr, 16'h0010);
    cyc();
    idle_inputs();
    #1;
    chk("pre_no_rvalid", {c_rvalid, q_rvalid, s_rvalid}, 0);

    // Single sequencer read
    s_valid = 1; s_addr = 16'h0010;
    #1;
    chk("sr_s_ready", s_ready, 1);
    chk("sr_mem_addr", mem_addr, 16'h0010);
    chk("sr_mem_wen", mem_wen, 0);
    cyc();
    s_valid = 0;
    #1;
    chk("sr_s_rvalid", s_rvalid, 1);
    chk("sr_s_rdata", s_rdata, 32'h55667788);
    chk("sr_other_rvalid", {c_rvalid, q_rvalid}, 0);
    cyc();
    chk("sr_pulse_end", s_rvalid, 0);

    // Compute lane-0 write, then QPI read of the same address
    c_valid = 1; c_addr = 16'h0100; c_wen = 8'h01; c_wdata = 64'hA5;
    #1;
    chk("wr_c_ready", c_ready, 1);
    cyc();
    idle_inputs();
    q_valid = 1; q_addr = 16'h0100; q_wen = 2'b00;
    #1;
    chk("wr_q_ready", q_ready, 1);
    chk("wr_no_rvalid", {c_rvalid, q_rvalid, s_rvalid}, 0);
    chk("wr_mem_addr", mem_addr, 16'h0100);
    cyc();
    q_valid = 0;
    #1;
    chk("rd_q_rvalid", q_rvalid, 1);
    chk("rd_q_rdata", q_rdata[7:0], 8'hA5);
    chk("rd_c_rvalid", c_rvalid, 0);
    cyc();

    // Compute vs QPI writes: QPI forced every 5th cycle
    c_valid = 1; c_addr = 16'h0200; c_wen = 8'h00;
    q_valid = 1; q_addr = 16'h0300; q_wen = 2'b11; q_wdata = 16'hBEEF;
    for (int k = 1; k <= 10; k++) begin
      #1;
      w = (k % 5 == 0);
      chk("st_q_ready", q_ready, w);
      chk("st_c_ready", c_ready, !w);
      chk("st_stall", stall, 1);
      if (w) begin
        chk("st_mem_wen", mem_wen, 8'h03);
        chk("st_mem_wdata", mem_wdata, 64'hBEEF);
      end
      if (k > 1) chk("st_c_rvalid", c_rvalid, ((k - 1) % 5) != 0);
      cyc();
    end
    idle_inputs();
    cyc();

    // All three requesting reads: QPI at 5, sequencer at 6, repeating
    c_valid = 1; c_addr = 16'h0010;
    q_valid = 1; q_addr = 16'h0010;
    s_valid = 1; s_addr = 16'h0010;
    prev_g = 3'b000;
    for (int k = 1; k <= 11; k++) begin
      #1;
      if (k % 5 == 0)               exp_g = 3'b010;
      else if (k % 5 == 1 && k > 1) exp_g = 3'b001;
      else                          exp_g = 3'b100;
      chk("ds_grant", {c_ready, q_ready, s_ready}, exp_g);
      chk("ds_rvalid", {c_rvalid, q_rvalid, s_rvalid}, prev_g);
      prev_g = exp_g;
      cyc();
    end
    idle_inputs();
    cyc();

    // Reset while a compute read is returning and QPI is at the limit
    c_valid = 1; c_addr = 16'h0010; c_wen = 8'h00;
    q_valid = 1; q_addr = 16'h0100; q_wen = 2'b00;
    cyc(); cyc(); cyc(); cyc();
    #1;
    chk("mr_c_rvalid_pre", c_rvalid, 1);
    chk("mr_q_forced_pre", q_ready, 1);
    #1;
    reset = 1'b1;
    #1;
    chk("mr_c_rvalid_rst", c_rvalid, 0);
    chk("mr_q_ready_rst", q_ready, 0);
    chk("mr_c_ready_rst", c_ready, 1);
    @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    chk("mr_q_ready_post", q_ready, 0);
    chk("mr_stall_post", stall, 1);
    chk("mr_no_rvalid_post", {c_rvalid, q_rvalid, s_rvalid}, 0);
    c_valid = 0;
    #1;
    chk("mr_q_grant", q_ready, 1);
    cyc();
    q_valid = 0;
    #1;
    chk("mr_q_rvalid", q_rvalid, 1);
    chk("mr_c_rvalid", c_rvalid, 0);
    cyc();

    // Idle
    idle_inputs();
    #1;
    chk_idle("idle");
    chk("idle_rvalids", {c_rvalid, q_rvalid, s_rvalid}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mlaccel_memarb.md
# mlaccel_memarb

Arbiter for the single-ported main memory (`mlaccel_memory`). It shares the memory between three requesters: the compute unit (64-bit), the QPI command path (16-bit) and the sequencer instruction fetch (32-bit). Default priority is fixed (compute > QPI > sequencer), and per-requester starvation counters force occasional grants to the lower ports. The block issues at most one access per cycle and returns read data with a per-requester `rvalid` one cycle after issue.

## Interface
Parameters:
- `STARVE_LIMIT`, 8: consecutive stalled cycles after which a QPI or sequencer request is force-granted over compute; legal range 1..255.

Ports:
- `clock` in 1: sole clock; everything is posedge.
- `reset` in 1: **asynchronous, active-high**.
- `c_valid` in 1: compute request.
- `c_ready` out 1: compute request issued this cycle.
- `c_addr` in 16: compute address.
- `c_wen` in 8: byte-lane write enables; 0 means read.
- `c_wdata` in 64: compute write data.
- `c_rvalid` out 1: compute read data valid.
- `c_rdata` out 64: compute read data.
- `q_valid` in 1, `q_ready` out 1, `q_addr` in 16: QPI request handshake and address.
- `q_wen` in 2: QPI lane enables; 0 means read.
- `q_wdata` in 16: QPI write data.
- `q_rvalid` out 1, `q_rdata` out 16: QPI read return.
- `s_valid` in 1, `s_ready` out 1, `s_addr` in 16: sequencer request; always a read.
- `s_rvalid` out 1, `s_rdata` out 32: sequencer read return.
- `mem_addr` out 16, `mem_wen` out 8, `mem_wdata` out 64: to `mlaccel_memory`.
- `mem_rdata` in 64: from `mlaccel_memory`; valid one cycle after the address.
- `stall` out 1: some valid requester was not granted this cycle.

## Operation
- **Handshake.** A request transfers in a cycle where `x_valid && x_ready`. Requesters hold valid, addr, wen and wdata stable until ready. `x_ready` is combinational from the valids and the wait counters, and is never high without `x_valid`.
- **Grant selection**, evaluated each cycle, first match wins:
  1. QPI is force-granted if `q_valid` and `wait_q == STARVE_LIMIT`.
  2. Sequencer is force-granted if `s_valid` and `wait_s == STARVE_LIMIT`.
  3. Otherwise compute if `c_valid`, then QPI if `q_valid`, then sequencer if `s_valid`.
- **Wait counters** (`wait_q`, `wait_s`, 8 bits):
  - Increment, saturating at `STARVE_LIMIT`, when `x_valid && !x_ready`.
  - Clear to 0 when `!x_valid` or `x_ready`.
  - Compute has no counter.
  - When both counters are at the limit, QPI is granted first; the sequencer is forced in the following cycle.
- **Memory drive (combinational):**
  - Compute granted: `mem_addr = c_addr`, `mem_wen = c_wen`, `mem_wdata = c_wdata`.
  - QPI granted: `mem_addr = q_addr`, `mem_wen = {6'b0, q_wen}`, `mem_wdata = {48'b0, q_wdata}`.
  - Sequencer granted: `mem_addr = s_addr`, `mem_wen = 0`, `mem_wdata = 0`.
  - No grant: all `mem_*` outputs are 0.
- **Read return.** A read issue (granted with wen == 0) registers a one-hot return tag. The next cycle, exactly that requester's `rvalid` pulses for one cycle. Writes produce no `rvalid`.
  - `c_rdata = mem_rdata`.
  - `q_rdata = mem_rdata[15:0]`.
  - `s_rdata = mem_rdata[31:0]`.
  - Read data is valid only while the matching `rvalid` is high.
- **`stall`** (combinational) = `(c_valid && !c_ready) || (q_valid && !q_ready) || (s_valid && !s_ready)`.

## Timing
- **Reset.** Clears the wait counters and the return tag, asynchronously.
  - Values during and after reset: all `rvalid` = 0; `stall` and `ready` follow the inputs combinationally (counters are 0, so fixed priority applies).
  - A read issued in the cycle before reset asserts never returns `rvalid`.
- **Latency.** Issue at edge N gives `rvalid` high in cycle N+1. Back-to-back issues sustain one access per cycle; return order equals issue order.
- **Simultaneous events.**
  - A read issue at edge N and the return of the issue at N-1 coexist. The `rvalid` outputs are tag-driven, so two different requesters never have `rvalid` high in the same cycle.
  - A granted requester's counter clears in the same edge as the grant.
- **Worst-case wait.** A QPI or sequencer request is granted within `STARVE_LIMIT + 1` cycles of asserting valid, or `STARVE_LIMIT + 2` for the sequencer when both are starving.
- **Compute stalls.** Compute sees `c_ready = 0` only in forced-grant cycles.

## Test plan
- **Single read.** `STARVE_LIMIT = 4`. Preload addr 0x0010 = 0x1122334455667788. `s_valid`, `s_addr = 0x0010` → `s_ready` high the same cycle; next cycle `s_rvalid = 1`, `s_rdata = 0x55667788`, other rvalids 0.
- **Priority and starvation.** Hold `c_valid` continuously and `q_valid` continuously. Required:
  - `q_ready` high only in every 5th cycle; `c_ready` low exactly in those cycles; `stall` high every cycle.
  - Each QPI write with `q_wen = 2'b11`, `q_wdata = 0xBEEF` appears as `mem_wen = 8'h03`, `mem_wdata = 0x...BEEF`.
- **Dual starvation.** Continuous compute, QPI and sequencer requests, `STARVE_LIMIT = 4`. Required: QPI is forced at cycle 5 and the sequencer at cycle 6; the pattern then repeats and neither requester ever waits more than 6 cycles.
- **Write then read.** Compute writes 0xA5 to lane 0 of addr 0x0100 (`c_wen = 8'h01`). Next cycle QPI reads 0x0100 → `q_rvalid` the following cycle with `q_rdata[7:0] = 0xA5`; no `rvalid` for the write.
- **Reset mid-read.** Issue `c_valid` read at edge N and assert reset asynchronously during cycle N+1 → `c_rvalid` drops to 0 immediately and the wait counters are 0. After release, the first QPI request is granted in the same cycle.
- **Idle.** No valids → `mem_addr = 0`, `mem_wen = 0`, `mem_wdata = 0`, `stall = 0`, all readies 0.
